// File: rtl/smi_frame_arbiter_x2.sv
// Two-to-one SMI frame arbiter: forwards whole frames from port A or B onto one registered output.
// Define SMI_ARB_FIXED_PRIORITY_EN to make port A win every contention; default is round-robin.
module smi_frame_arbiter_x2 #(
    parameter int FlitWidth = 4
) (
    input  logic                   clk,
    input  logic                   srst,

    input  logic                   smiInAReady,
    input  logic [7:0]             smiInAEofc,
    input  logic [FlitWidth*8-1:0] smiInAData,
    output logic                   smiInAStop,

    input  logic                   smiInBReady,
    input  logic [7:0]             smiInBEofc,
    input  logic [FlitWidth*8-1:0] smiInBData,
    output logic                   smiInBStop,

    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    output logic                   smiOutSel,
    input  logic                   smiOutStop
);

    localparam int DW = FlitWidth * 8;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_e;

    state_e          state_q, state_d;
    logic            lastGrant_q, lastGrant_d;

    logic            readyA_q, readyA_d;
    logic [7:0]      eofcA_q, eofcA_d;
    logic [DW-1:0]   dataA_q, dataA_d;
    logic            lastA_q, lastA_d;

    logic            readyB_q, readyB_d;
    logic [7:0]      eofcB_q, eofcB_d;
    logic [DW-1:0]   dataB_q, dataB_d;
    logic            lastB_q, lastB_d;

    logic            outReady_q, outReady_d;
    logic [7:0]      outEofc_q, outEofc_d;
    logic [DW-1:0]   outData_q, outData_d;
    logic            outSel_q, outSel_d;

    logic            outAccept;
    logic            selB;
    logic            selReady;
    logic            selLast;
    logic            xfer;
    logic            haltA, haltB;
    logic            loadA, loadB;

    assign outAccept = ~(outReady_q & smiOutStop);

    // ------------------------------------------------------------------
    // FSM state register (lastGrant travels with it)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        if (xfer) begin
            if (selLast) begin
                state_d     = IDLE;
                lastGrant_d = selB;
            end else if (selB) begin
                state_d = OWN_B;
            end else begin
                state_d = OWN_A;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs: port selection and transfer qualification
    // ------------------------------------------------------------------
    always_comb begin
        selB = 1'b0;
        case (state_q)
            OWN_A: selB = 1'b0;
            OWN_B: selB = 1'b1;
            default: begin
                if (readyA_q && readyB_q) begin
`ifdef SMI_ARB_FIXED_PRIORITY_EN
                    selB = 1'b0;
`else
                    selB = ~lastGrant_q;
`endif
                end else if (readyB_q) begin
                    selB = 1'b1;
                end else begin
                    selB = 1'b0;
                end
            end
        endcase

        selReady = selB ? readyB_q : readyA_q;
        selLast  = selB ? lastB_q  : lastA_q;
        xfer     = selReady & outAccept;
        haltA    = ~(~selB & outAccept);
        haltB    = ~(selB & outAccept);
    end

    // ------------------------------------------------------------------
    // Input stages: a full register that is not being drained holds off upstream
    // ------------------------------------------------------------------
    assign smiInAStop = readyA_q & haltA;
    assign smiInBStop = readyB_q & haltB;
    assign loadA      = ~smiInAStop;
    assign loadB      = ~smiInBStop;

    always_comb begin
        readyA_d = readyA_q;
        eofcA_d  = eofcA_q;
        dataA_d  = dataA_q;
        lastA_d  = lastA_q;
        if (loadA) begin
            readyA_d = smiInAReady;
            eofcA_d  = smiInAEofc;
            dataA_d  = smiInAData;
            lastA_d  = (smiInAEofc != '0);
        end
    end

    always_comb begin
        readyB_d = readyB_q;
        eofcB_d  = eofcB_q;
        dataB_d  = dataB_q;
        lastB_d  = lastB_q;
        if (loadB) begin
            readyB_d = smiInBReady;
            eofcB_d  = smiInBEofc;
            dataB_d  = smiInBData;
            lastB_d  = (smiInBEofc != '0);
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        outReady_d = outReady_q;
        outEofc_d  = outEofc_q;
        outData_d  = outData_q;
        outSel_d   = outSel_q;
        if (outAccept) begin
            outReady_d = xfer;
            outEofc_d  = selB ? eofcB_q : eofcA_q;
            outData_d  = selB ? dataB_q : dataA_q;
            outSel_d   = selB;
        end
    end

    // Control flops are reset; payload flops are not, since ready qualifies them.
    always_ff @(posedge clk) begin
        if (srst) begin
            readyA_q   <= 1'b0;
            readyB_q   <= 1'b0;
            outReady_q <= 1'b0;
            outSel_q   <= 1'b0;
        end else begin
            readyA_q   <= readyA_d;
            readyB_q   <= readyB_d;
            outReady_q <= outReady_d;
            outSel_q   <= outSel_d;
        end
    end

    always_ff @(posedge clk) begin
        eofcA_q   <= eofcA_d;
        dataA_q   <= dataA_d;
        lastA_q   <= lastA_d;
        eofcB_q   <= eofcB_d;
        dataB_q   <= dataB_d;
        lastB_q   <= lastB_d;
        outEofc_q <= outEofc_d;
        outData_q <= outData_d;
    end

    assign smiOutReady = outReady_q;
    assign smiOutEofc  = outEofc_q;
    assign smiOutData  = outData_q;
    assign smiOutSel   = outSel_q;

endmodule

// File: tb/tb_smi_frame_arbiter_x2.sv
// Bench for smi_frame_arbiter_x2: directed frame scenarios plus randomized traffic against
// per-port in-order scoreboards and a frame-atomicity rule.
module tb_smi_frame_arbiter_x2;

    localparam int FW = 4;
    localparam int DW = FW * 8;

    typedef struct {
        int unsigned   gap;
        logic [7:0]    e;
        logic [DW-1:0] d;
    } flit_t;

    typedef struct {
        int            cyc;
        logic          sel;
        logic [7:0]    e;
        logic [DW-1:0] d;
    } obs_t;

    logic          clk = 1'b0;
    logic          srst;
    logic          smiInAReady, smiInBReady;
    logic [7:0]    smiInAEofc, smiInBEofc;
    logic [DW-1:0] smiInAData, smiInBData;
    logic          smiInAStop, smiInBStop;
    logic          smiOutReady;
    logic [7:0]    smiOutEofc;
    logic [DW-1:0] smiOutData;
    logic          smiOutSel;
    logic          smiOutStop;

    smi_frame_arbiter_x2 #(.FlitWidth(FW)) dut (
        .clk        (clk),
        .srst       (srst),
        .smiInAReady(smiInAReady),
        .smiInAEofc (smiInAEofc),
        .smiInAData (smiInAData),
        .smiInAStop (smiInAStop),
        .smiInBReady(smiInBReady),
        .smiInBEofc (smiInBEofc),
        .smiInBData (smiInBData),
        .smiInBStop (smiInBStop),
        .smiOutReady(smiOutReady),
        .smiOutEofc (smiOutEofc),
        .smiOutData (smiOutData),
        .smiOutSel  (smiOutSel),
        .smiOutStop (smiOutStop)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stopPct = 0;
    flit_t       pendA[$], pendB[$];
    flit_t       expA[$], expB[$];
    obs_t        logq[$], want[$];
    flit_t       curA, curB;
    bit          aPres, bPres;
    int unsigned gapA, gapB;
    bit          outOpen;
    logic        outOwner;
    bit          stopForce[int];
    bit          stopALog[int], stopBLog[int], outRLog[int];
    logic [DW-1:0] outDLog[int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic addFlit(input bit port, input int unsigned gap, input logic [7:0] e, input logic [DW-1:0] d);
        flit_t f;
        f.gap = gap;
        f.e   = e;
        f.d   = d;
        if (port) pendB.push_back(f);
        else      pendA.push_back(f);
    endtask

    task automatic wantAdd(input int c, input logic sel, input logic [7:0] e, input logic [DW-1:0] d);
        obs_t o;
        o.cyc = c;
        o.sel = sel;
        o.e   = e;
        o.d   = d;
        want.push_back(o);
    endtask

    // Output side: per-port FIFO order and no interleaving inside a frame.
    task automatic monitor();
        obs_t  o;
        flit_t f;
        o.cyc = cyc;
        o.sel = smiOutSel;
        o.e   = smiOutEofc;
        o.d   = smiOutData;
        logq.push_back(o);
        if (outOpen) check("atomic_sel", 64'(smiOutSel), 64'(outOwner));
        if (smiOutSel == 1'b0) begin
            if (expA.size() == 0) check("sb_a_underflow", 64'(expA.size()), 64'(1));
            else begin
                f = expA.pop_front();
                check("sb_a_flit", 64'({smiOutEofc, smiOutData}), 64'({f.e, f.d}));
            end
        end else begin
            if (expB.size() == 0) check("sb_b_underflow", 64'(expB.size()), 64'(1));
            else begin
                f = expB.pop_front();
                check("sb_b_flit", 64'({smiOutEofc, smiOutData}), 64'({f.e, f.d}));
            end
        end
        outOpen  = (smiOutEofc == 8'd0);
        outOwner = smiOutSel;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!aPres && pendA.size() != 0) begin
            if (gapA < pendA[0].gap) gapA++;
            else begin curA = pendA.pop_front(); aPres = 1'b1; gapA = 0; end
        end
        if (!bPres && pendB.size() != 0) begin
            if (gapB < pendB[0].gap) gapB++;
            else begin curB = pendB.pop_front(); bPres = 1'b1; gapB = 0; end
        end
        smiInAReady = aPres;
        smiInAEofc  = aPres ? curA.e : 8'($urandom);
        smiInAData  = aPres ? curA.d : DW'($urandom);
        smiInBReady = bPres;
        smiInBEofc  = bPres ? curB.e : 8'($urandom);
        smiInBData  = bPres ? curB.d : DW'($urandom);
        smiOutStop  = stopForce.exists(cyc) ? 1'b1 : ($urandom_range(99) < 32'(stopPct));
        #1;
        stopALog[cyc] = smiInAStop;
        stopBLog[cyc] = smiInBStop;
        outRLog[cyc]  = smiOutReady;
        outDLog[cyc]  = smiOutData;
        if (smiOutReady && !smiOutStop) monitor();
        if (aPres && !smiInAStop) begin expA.push_back(curA); aPres = 1'b0; end
        if (bPres && !smiInBStop) begin expB.push_back(curB); bPres = 1'b0; end
    endtask

    task automatic doReset();
        @(negedge clk);
        cyc++;
        srst        = 1'b1;
        smiInAReady = 1'b0;
        smiInBReady = 1'b0;
        smiOutStop  = 1'b0;
        pendA.delete(); pendB.delete();
        expA.delete();  expB.delete();
        aPres = 1'b0; bPres = 1'b0;
        gapA  = 0;    gapB  = 0;
        outOpen = 1'b0;
        @(negedge clk);
        cyc++;
        srst = 1'b0;
        #1;
        check("reset_out_ready", 64'(smiOutReady), 64'(0));
        check("reset_stop_a", 64'(smiInAStop), 64'(0));
        check("reset_stop_b", 64'(smiInBStop), 64'(0));
        check("reset_out_sel", 64'(smiOutSel), 64'(0));
    endtask

    task automatic compareLog(input string tag);
        check({tag, "_count"}, 64'(logq.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < logq.size(); i++) begin
            check({tag, "_cycle"}, 64'(logq[i].cyc), 64'(want[i].cyc));
            check({tag, "_flit"}, 64'({logq[i].sel, logq[i].e, logq[i].d}),
                  64'({want[i].sel, want[i].e, want[i].d}));
        end
    endtask

    int s;
    int n;
    int len;
    int total;

    initial begin
        srst = 1'b1;
        smiInAReady = 1'b0; smiInAEofc = '0; smiInAData = '0;
        smiInBReady = 1'b0; smiInBEofc = '0; smiInBData = '0;
        smiOutStop  = 1'b0;
        doReset();

        // Single port, 3-flit frame, 2-cycle latency, back-to-back output.
        logq.delete(); want.delete(); s = cyc + 1;
        addFlit(1'b0, 0, 8'd0, 'h11);
        addFlit(1'b0, 0, 8'd0, 'h22);
        addFlit(1'b0, 0, 8'd4, 'h33);
        repeat (7) step();
        wantAdd(s + 2, 1'b0, 8'd0, 'h11);
        wantAdd(s + 3, 1'b0, 8'd0, 'h22);
        wantAdd(s + 4, 1'b0, 8'd4, 'h33);
        compareLog("single");

        // Two 2-flit frames per port offered from the same cycle after reset.
        doReset();
        logq.delete(); want.delete(); s = cyc + 1;
        addFlit(1'b0, 0, 8'd0, 'hA0); addFlit(1'b0, 0, 8'd1, 'hA1);
        addFlit(1'b0, 0, 8'd0, 'hA2); addFlit(1'b0, 0, 8'd2, 'hA3);
        addFlit(1'b1, 0, 8'd0, 'hB0); addFlit(1'b1, 0, 8'd3, 'hB1);
        addFlit(1'b1, 0, 8'd0, 'hB2); addFlit(1'b1, 0, 8'd4, 'hB3);
        repeat (12) step();
`ifdef SMI_ARB_FIXED_PRIORITY_EN
        wantAdd(s + 2, 1'b0, 8'd0, 'hA0); wantAdd(s + 3, 1'b0, 8'd1, 'hA1);
        wantAdd(s + 4, 1'b0, 8'd0, 'hA2); wantAdd(s + 5, 1'b0, 8'd2, 'hA3);
        wantAdd(s + 6, 1'b1, 8'd0, 'hB0); wantAdd(s + 7, 1'b1, 8'd3, 'hB1);
        wantAdd(s + 8, 1'b1, 8'd0, 'hB2); wantAdd(s + 9, 1'b1, 8'd4, 'hB3);
`else
        wantAdd(s + 2, 1'b0, 8'd0, 'hA0); wantAdd(s + 3, 1'b0, 8'd1, 'hA1);
        wantAdd(s + 4, 1'b1, 8'd0, 'hB0); wantAdd(s + 5, 1'b1, 8'd3, 'hB1);
        wantAdd(s + 6, 1'b0, 8'd0, 'hA2); wantAdd(s + 7, 1'b0, 8'd2, 'hA3);
        wantAdd(s + 8, 1'b1, 8'd0, 'hB2); wantAdd(s + 9, 1'b1, 8'd4, 'hB3);
`endif
        compareLog("contention");

        // A lone A frame makes B the round-robin favourite for the next contention.
        doReset();
        addFlit(1'b0, 0, 8'd1, 'h5A5A);
        repeat (5) step();
        logq.delete(); want.delete(); s = cyc + 1;
        addFlit(1'b0, 0, 8'd0, 'hC0); addFlit(1'b0, 0, 8'd1, 'hC1);
        addFlit(1'b1, 0, 8'd0, 'hD0); addFlit(1'b1, 0, 8'd2, 'hD1);
        repeat (8) step();
`ifdef SMI_ARB_FIXED_PRIORITY_EN
        wantAdd(s + 2, 1'b0, 8'd0, 'hC0); wantAdd(s + 3, 1'b0, 8'd1, 'hC1);
        wantAdd(s + 4, 1'b1, 8'd0, 'hD0); wantAdd(s + 5, 1'b1, 8'd2, 'hD1);
`else
        wantAdd(s + 2, 1'b1, 8'd0, 'hD0); wantAdd(s + 3, 1'b1, 8'd2, 'hD1);
        wantAdd(s + 4, 1'b0, 8'd0, 'hC0); wantAdd(s + 5, 1'b0, 8'd1, 'hC1);
`endif
        compareLog("rr_after_a");

        // A idles 3 cycles mid-frame; B must wait for A's last flit.
        doReset();
        logq.delete(); want.delete(); s = cyc + 1;
        addFlit(1'b0, 0, 8'd0, 'hA0); addFlit(1'b0, 3, 8'd0, 'hA1); addFlit(1'b0, 0, 8'd5, 'hA2);
        addFlit(1'b1, 1, 8'd0, 'hB0); addFlit(1'b1, 0, 8'd7, 'hB1);
        repeat (12) step();
        wantAdd(s + 2, 1'b0, 8'd0, 'hA0); wantAdd(s + 6, 1'b0, 8'd0, 'hA1);
        wantAdd(s + 7, 1'b0, 8'd5, 'hA2); wantAdd(s + 8, 1'b1, 8'd0, 'hB0);
        wantAdd(s + 9, 1'b1, 8'd7, 'hB1);
        compareLog("atomic");
        check("atomic_stop_b_held1", 64'(stopBLog[s + 3]), 64'(1));
        check("atomic_stop_b_held2", 64'(stopBLog[s + 5]), 64'(1));
        check("atomic_stop_b_free", 64'(stopBLog[s + 7]), 64'(0));

        // Output stall of 4 cycles mid-frame.
        doReset();
        logq.delete(); want.delete(); s = cyc + 1;
        addFlit(1'b0, 0, 8'd0, 'hD0); addFlit(1'b0, 0, 8'd0, 'hD1);
        addFlit(1'b0, 0, 8'd0, 'hD2); addFlit(1'b0, 0, 8'd8, 'hD3);
        for (int i = 3; i <= 6; i++) stopForce[s + i] = 1'b1;
        repeat (12) step();
        wantAdd(s + 2, 1'b0, 8'd0, 'hD0); wantAdd(s + 7, 1'b0, 8'd0, 'hD1);
        wantAdd(s + 8, 1'b0, 8'd0, 'hD2); wantAdd(s + 9, 1'b0, 8'd8, 'hD3);
        compareLog("stall");
        for (int i = 3; i <= 6; i++) begin
            check("stall_hold_ready", 64'(outRLog[s + i]), 64'(1));
            check("stall_hold_data", 64'(outDLog[s + i]), 64'('hD1));
        end
        for (int i = 4; i <= 6; i++) check("stall_stop_a", 64'(stopALog[s + i]), 64'(1));
        check("stall_stop_a_release", 64'(stopALog[s + 7]), 64'(0));

        // Reset while A is mid-frame, then a B frame must go straight through.
        doReset();
        addFlit(1'b0, 0, 8'd0, 'hE0); addFlit(1'b0, 0, 8'd0, 'hE1); addFlit(1'b0, 0, 8'd0, 'hE2);
        repeat (3) step();
        doReset();
        logq.delete(); want.delete(); s = cyc + 1;
        addFlit(1'b1, 0, 8'd0, 'hF0); addFlit(1'b1, 0, 8'd6, 'hF1);
        repeat (6) step();
        wantAdd(s + 2, 1'b1, 8'd0, 'hF0); wantAdd(s + 3, 1'b1, 8'd6, 'hF1);
        compareLog("reset_mid");

        // Continuous single-flit frames on both ports.
        doReset();
        logq.delete(); want.delete(); s = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            addFlit(1'b0, 0, 8'd1, DW'(32'hA100 + i));
            addFlit(1'b1, 0, 8'd1, DW'(32'hB100 + i));
        end
        repeat (16) step();
        for (int i = 0; i < 12; i++) begin
`ifdef SMI_ARB_FIXED_PRIORITY_EN
            if (i < 6) wantAdd(s + 2 + i, 1'b0, 8'd1, DW'(32'hA100 + i));
            else       wantAdd(s + 2 + i, 1'b1, 8'd1, DW'(32'hB100 + i - 6));
`else
            if (i % 2 == 0) wantAdd(s + 2 + i, 1'b0, 8'd1, DW'(32'hA100 + i / 2));
            else            wantAdd(s + 2 + i, 1'b1, 8'd1, DW'(32'hB100 + i / 2));
`endif
        end
        compareLog("single_flit_stream");

        // Randomized frames, gaps and output stalls.
        doReset();
        logq.delete();
        stopPct = 25;
        total = 0;
        for (int f = 0; f < 30; f++) begin
            for (int p = 0; p < 2; p++) begin
                len = $urandom_range(1, 5);
                for (int k = 0; k < len; k++) begin
                    addFlit(bit'(p), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                            (k == len - 1) ? 8'($urandom_range(1, 255)) : 8'd0, DW'($urandom));
                    total++;
                end
            end
        end
        n = 0;
        while (!(pendA.size() == 0 && pendB.size() == 0 && !aPres && !bPres &&
                 expA.size() == 0 && expB.size() == 0) && n < 4000) begin
            step();
            n++;
        end
        check("random_drain_in_budget", 64'(n < 4000), 64'(1));
        check("random_flit_count", 64'(logq.size()), 64'(total));
        stopPct = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
